// File: rtl/booth_job_sequencer_if.sv
// Handshake and multiplier-side signals of the Booth job sequencer.
// master = the environment (producer, multiplier, consumer), slave = the sequencer.
interface booth_job_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_mcand;
  logic [WIDTH-1:0]       in_mplier;
  logic [WIDTH-1:0]       mult_M;
  logic [WIDTH-1:0]       mult_Q;
  logic                   mult_start;
  logic                   mult_abort;
  logic                   mult_done;
  logic [2*WIDTH-1:0]     mult_product;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     out_product;
  logic                   err_timeout;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output in_valid, in_mcand, in_mplier, mult_done, mult_product, out_ready,
    input  in_ready, mult_M, mult_Q, mult_start, mult_abort, out_valid, out_product,
           err_timeout, fifo_count
  );

  modport slave (
    input  in_valid, in_mcand, in_mplier, mult_done, mult_product, out_ready,
    output in_ready, mult_M, mult_Q, mult_start, mult_abort, out_valid, out_product,
           err_timeout, fifo_count
  );
endinterface

// File: rtl/booth_job_sequencer.sv
// Operand FIFO plus one-job-at-a-time launcher for the Booth multiplier, with result
// register on a valid/ready stream and a watchdog that aborts a hung multiply.
module booth_job_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input logic                   clock,
  input logic                   reset,
  booth_job_sequencer_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, WAIT_DONE, SETTLE, CAPTURE, OUTPUT, ABORT
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
  } job_t;

  job_t               mem_q [DEPTH];
  job_t               mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [WIDTH-1:0]   m_q, m_d, q_q, q_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_product_q, out_product_d;
  logic               err_q, err_d;
  logic               push, pop;

  assign push = bus.in_valid && (count_q != FULL);
  assign pop  = (state_q == IDLE) && (count_q != '0);

  // Pointers are AW bits wide, so they wrap mod DEPTH for free.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = '{mcand: bus.in_mcand, mplier: bus.in_mplier};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    m_d           = m_q;
    q_d           = q_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    err_d         = err_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          m_d     = mem_q[rd_ptr_q].mcand;
          q_d     = mem_q[rd_ptr_q].mplier;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      // done must drop before it is trusted, so a stale 1 cannot finish the job
      WAIT_ACK: begin
        if (!bus.mult_done) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q == TMAX) begin
          state_d = ABORT;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.mult_done) begin
          state_d = SETTLE;
        end else if (timer_q == TMAX) begin
          state_d = ABORT;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      SETTLE: state_d = CAPTURE;
      CAPTURE: begin
        out_product_d = bus.mult_product;
        out_valid_d   = 1'b1;
        state_d       = OUTPUT;
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      ABORT: begin
        err_d   = 1'b1;
        timer_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      timer_q       <= '0;
      m_q           <= '0;
      q_q           <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      m_q           <= m_d;
      q_q           <= q_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      err_q         <= err_d;
    end
  end

  assign bus.in_ready    = (count_q != FULL);
  assign bus.fifo_count  = count_q;
  assign bus.mult_M      = m_q;
  assign bus.mult_Q      = q_q;
  assign bus.mult_start  = (state_q == ISSUE);
  assign bus.mult_abort  = (state_q == ABORT);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_booth_job_sequencer.sv
// Scoreboard bench for booth_job_sequencer with a behavioural Booth multiplier model.
module tb_booth_job_sequencer;
  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic clock = 1'b0;
  logic reset = 1'b0;

  booth_job_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  booth_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0;
  int n_start = 0, n_abort = 0, start_cyc = 0, abort_cyc = 0;
  logic [2*WIDTH-1:0] sb[$];
  int ack_dly = 0, lat = 3;
  bit stuck = 1'b0;

  function automatic logic [2*WIDTH-1:0] ref_prod(int m, int q);
    logic signed [WIDTH-1:0] a, b;
    int p;
    a = WIDTH'(m);
    b = WIDTH'(q);
    p = int'(a) * int'(b);
    return p[2*WIDTH-1:0];
  endfunction

  // Multiplier model: keeps done high while idle, drops it after ack_dly cycles,
  // raises it with the product lat cycles later. stuck=1 ignores start entirely.
  initial begin
    bus.mult_done    = 1'b0;
    bus.mult_product = '0;
    forever begin
      @(negedge clock);
      if (bus.mult_start && !reset && !stuck) begin
        logic [WIDTH-1:0] mm, mq;
        mm = bus.mult_M;
        mq = bus.mult_Q;
        @(posedge clock); #1;
        repeat (ack_dly) begin @(posedge clock); #1; end
        bus.mult_done = 1'b0;
        repeat (lat) begin @(posedge clock); #1; end
        bus.mult_product = ref_prod(int'(mm), int'(mq));
        bus.mult_done    = 1'b1;
      end
    end
  end

  // One clock: observe at negedge (pulses, output handshake vs scoreboard), resume at posedge+1.
  task automatic step();
    logic [2*WIDTH-1:0] e;
    @(negedge clock);
    if (!reset) begin
      if (bus.mult_start) begin n_start++; start_cyc = cyc; end
      if (bus.mult_abort) begin n_abort++; abort_cyc = cyc; end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected got=%h want=none", bus.out_product);
        end else begin
          e = sb.pop_front();
          if (bus.out_product !== e) begin
            bad++;
            $display("FAIL out_product got=%h want=%h", bus.out_product, e);
          end
        end
      end
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic push(int m, int q, bit exp);
    bit acc;
    int n;
    bus.in_valid  = 1'b1;
    bus.in_mcand  = WIDTH'(m);
    bus.in_mplier = WIDTH'(q);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      acc = bus.in_ready;
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL push_timeout got=in_ready0 want=accept");
    end else if (exp) begin
      sb.push_back(ref_prod(m, q));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 400) begin step(); n++; end
    total++;
    if (sb.size() != 0 || bus.out_valid) begin
      bad++;
      $display("FAIL drain_timeout got=pending%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({bus.mult_start, bus.mult_abort, bus.out_valid, bus.err_timeout} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000",
               {bus.mult_start, bus.mult_abort, bus.out_valid, bus.err_timeout});
    end
    total++;
    if ({bus.mult_M, bus.mult_Q, bus.out_product} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0", bus.mult_M, bus.mult_Q, bus.out_product);
    end
    reset = 1'b0;
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.fifo_count !== '0) begin
      bad++;
      $display("FAIL reset_fifo got=rdy%b cnt%0d want=rdy1 cnt0", bus.in_ready, bus.fifo_count);
    end
  endtask

  task automatic test_single();
    int n, s0;
    s0 = n_start;
    bus.out_ready = 1'b0;
    push(3, 2, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin step(); n++; end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_product !== 8'h06) begin
      bad++;
      $display("FAIL single_result got=v%b %h want=v1 06", bus.out_valid, bus.out_product);
    end
    repeat (5) step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_product !== 8'h06) begin
      bad++;
      $display("FAIL single_hold got=v%b %h want=v1 06", bus.out_valid, bus.out_product);
    end
    bus.out_ready = 1'b1;
    drain();
    total++;
    if (n_start - s0 !== 1) begin
      bad++;
      $display("FAIL single_starts got=%0d want=1", n_start - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = n_start;
    bus.out_ready = 1'b1;
    push(-4, 3, 1'b1);
    push(-1, -1, 1'b1);
    push(7, -8, 1'b1);
    drain();
    total++;
    if (n_start - s0 !== 3) begin
      bad++;
      $display("FAIL b2b_starts got=%0d want=3", n_start - s0);
    end
  endtask

  task automatic test_fifo_full();
    int s0;
    int cm[5] = '{1, 2, -8, -5, 0};
    int cq[5] = '{1, -3, -8, 4, 7};
    int ce[5] = '{1, 1, 2, 3, 4};
    s0 = n_start;
    bus.out_ready = 1'b0;
    // second push lands while IDLE pops the first: count must stay at 1
    for (int i = 0; i < 5; i++) begin
      push(cm[i], cq[i], 1'b1);
      total++;
      if (int'(bus.fifo_count) !== ce[i]) begin
        bad++;
        $display("FAIL fifo_count_%0d got=%0d want=%0d", i, bus.fifo_count, ce[i]);
      end
    end
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fifo_full_ready got=%b want=0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    drain();
    total++;
    if (n_start - s0 !== 5) begin
      bad++;
      $display("FAIL fifo_starts got=%0d want=5", n_start - s0);
    end
  endtask

  task automatic test_timeout();
    int n, s0, a0;
    s0 = n_start;
    a0 = n_abort;
    bus.out_ready = 1'b1;
    stuck = 1'b1;
    push(5, 5, 1'b0);
    n = 0;
    while (n_abort == a0 && n < 200) begin step(); n++; end
    total++;
    if (n_abort == a0 || abort_cyc - start_cyc !== TIMEOUT + 2) begin
      bad++;
      $display("FAIL abort_timing got=%0d want=%0d", abort_cyc - start_cyc, TIMEOUT + 2);
    end
    total++;
    if (bus.err_timeout !== 1'b1) begin
      bad++;
      $display("FAIL err_set got=%b want=1", bus.err_timeout);
    end
    repeat (2) step();
    total++;
    if (n_abort - a0 !== 1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse got=n%0d v%b want=n1 v0", n_abort - a0, bus.out_valid);
    end
    stuck = 1'b0;
    push(5, -3, 1'b1);
    drain();
    total++;
    if (bus.err_timeout !== 1'b1 || n_start - s0 !== 2) begin
      bad++;
      $display("FAIL after_abort got=e%b s%0d want=e1 s2", bus.err_timeout, n_start - s0);
    end
  endtask

  task automatic test_reset_mid();
    int n, s0;
    s0 = n_start;
    lat = 20;
    bus.out_ready = 1'b1;
    push(6, 7, 1'b0);
    push(1, 1, 1'b0);
    push(2, 2, 1'b0);
    n = 0;
    while (n_start == s0 && n < 50) begin step(); n++; end
    repeat (4) step();
    total++;
    if (bus.fifo_count !== 3'd2) begin
      bad++;
      $display("FAIL pre_reset_count got=%0d want=2", bus.fifo_count);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.mult_start, bus.mult_abort, bus.err_timeout} !== 4'b0000) begin
      bad++;
      $display("FAIL midreset_ctrl got=%b want=0000",
               {bus.out_valid, bus.mult_start, bus.mult_abort, bus.err_timeout});
    end
    total++;
    if (bus.fifo_count !== '0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_fifo got=cnt%0d rdy%b want=cnt0 rdy1", bus.fifo_count, bus.in_ready);
    end
    total++;
    if ({bus.mult_M, bus.mult_Q, bus.out_product} !== '0) begin
      bad++;
      $display("FAIL midreset_data got=%h/%h/%h want=0", bus.mult_M, bus.mult_Q, bus.out_product);
    end
    repeat (2) step();
    reset = 1'b0;
    repeat (30) step();
    total++;
    if (n_start - s0 !== 1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle got=s%0d v%b want=s1 v0", n_start - s0, bus.out_valid);
    end
    lat = 3;
  endtask

  task automatic test_stale_done();
    int n, s0, early;
    s0 = n_start;
    ack_dly = 6;
    lat = 2;
    bus.out_ready = 1'b1;
    push(-2, 5, 1'b1);
    n = 0;
    while (n_start == s0 && n < 50) begin step(); n++; end
    early = 0;
    repeat (8) begin
      step();
      if (bus.out_valid) early++;
    end
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL stale_done_early got=%0d want=0", early);
    end
    drain();
    total++;
    if (n_start - s0 !== 1) begin
      bad++;
      $display("FAIL stale_starts got=%0d want=1", n_start - s0);
    end
    ack_dly = 0;
    lat = 3;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mcand  = '0;
    bus.in_mplier = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    test_stale_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end
endmodule
